// File: rtl/mem_inc.sv
// Shared definitions for the unified memory block and its arbiter.
// Provides the architectural register type, access-size encoding, the
// mem params bus payload and the valid byte range of the memory.
package mem_inc;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned MEM_BYTES = 64 * 1024 * 1024;

  typedef logic [XLEN-1:0] arch_reg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } access_size_t;

  typedef struct packed {
    logic         read_write;       // 1 = read, 0 = write
    access_size_t access_size;
    logic         unsigned_access;  // 1 = zero-extend loads
  } mem_params_t;

  // Instruction fetch is always an unsigned word read.
  localparam mem_params_t FETCH_PARAMS = '{read_write: 1'b1, access_size: WORD, unsigned_access: 1'b1};
  // Harmless read presented whenever nothing legal is granted.
  localparam mem_params_t IDLE_PARAMS  = '{read_write: 1'b1, access_size: WORD, unsigned_access: 1'b1};

  // Number of bytes touched by an access; RSVD is rejected elsewhere.
  function automatic logic [2:0] access_bytes(input access_size_t size);
    case (size)
      BYTE:    access_bytes = 3'd1;
      HALF:    access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_align_check.sv
// Combinational legality check for one memory access.
// Ports: address (byte address), access_size (BYTE/HALF/WORD/RSVD),
//        err (misaligned, reserved size or beyond the memory range).
module mem_align_check
  import mem_inc::*;
#(
  parameter int unsigned MEM_BYTES = mem_inc::MEM_BYTES
) (
  input  arch_reg      address,
  input  access_size_t access_size,
  output logic         err
);

  // One extra bit so address + size cannot wrap around 2^32.
  localparam int unsigned EXT_W = XLEN + 1;

  logic             misaligned;
  logic             reserved;
  logic             out_of_range;
  logic [EXT_W-1:0] end_addr;

  always_comb begin
    misaligned = 1'b0;
    reserved   = 1'b0;
    case (access_size)
      BYTE:    misaligned = 1'b0;
      HALF:    misaligned = address[0];
      WORD:    misaligned = |address[1:0];
      default: reserved   = 1'b1;
    endcase
    end_addr     = EXT_W'(address) + EXT_W'(access_bytes(access_size));
    out_of_range = end_addr > EXT_W'(MEM_BYTES);
    err          = misaligned | reserved | out_of_range;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the unified mem block between instruction fetch and the LSU.
// Ports:
//   clock, reset                 - clock, synchronous active-high reset
//   if_req_*/if_rsp_*            - fetch request handshake and response pulse
//   d_req_*/d_rsp_*              - load/store request handshake and response
//   mem_address/data_in/params   - drive to mem, mem_data_out read back
// Data has priority; fetch is forced after STARVE_LIMIT consecutive data
// wins while it waited. Illegal accesses never reach mem as writes.
module mem_arbiter
  import mem_inc::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MEM_BYTES    = mem_inc::MEM_BYTES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  arch_reg     if_addr,
  output logic        if_rsp_valid,
  output arch_reg     if_rsp_data,
  output logic        if_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  arch_reg     d_addr,
  input  arch_reg     d_wdata,
  input  mem_params_t d_params,
  output logic        d_rsp_valid,
  output arch_reg     d_rsp_data,
  output logic        d_rsp_err,
  output arch_reg     mem_address,
  output arch_reg     mem_data_in,
  input  arch_reg     mem_data_out,
  output mem_params_t mem_params
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             grant_if;
  logic             grant_d;
  arch_reg          sel_addr;
  access_size_t     sel_size;
  logic             sel_err;

  // Grant selection: depends on request valids and the counter only.
  always_comb begin
    starved  = if_req_valid && (starve_cnt == CNT_W'(STARVE_LIMIT));
    grant_d  = !reset && d_req_valid && !starved;
    grant_if = !reset && if_req_valid && (!d_req_valid || starved);
  end

  assign if_req_ready = grant_if;
  assign d_req_ready  = grant_d;

  // Counts data wins while fetch waits; saturates at the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!if_req_valid || grant_if) begin
      starve_cnt <= '0;
    end else if (grant_d && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Single legality check on the granted request.
  always_comb begin
    sel_addr = grant_if ? if_addr : d_addr;
    sel_size = grant_if ? WORD : d_params.access_size;
  end

  mem_align_check #(
    .MEM_BYTES (MEM_BYTES)
  ) u_align (
    .address     (sel_addr),
    .access_size (sel_size),
    .err         (sel_err)
  );

  // Memory drive: only a legal granted request reaches mem.
  always_comb begin
    mem_address = '0;
    mem_data_in = '0;
    mem_params  = IDLE_PARAMS;
    if (grant_if && !sel_err) begin
      mem_address = if_addr;
      mem_params  = FETCH_PARAMS;
    end else if (grant_d && !sel_err) begin
      mem_address = d_addr;
      mem_data_in = d_wdata;
      mem_params  = d_params;
    end
  end

  // One-cycle response registers, captured at the edge ending the grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      if_rsp_err   <= 1'b0;
      d_rsp_valid  <= 1'b0;
      d_rsp_data   <= '0;
      d_rsp_err    <= 1'b0;
    end else begin
      if_rsp_valid <= grant_if;
      if_rsp_data  <= (grant_if && !sel_err) ? mem_data_out : '0;
      if_rsp_err   <= grant_if && sel_err;
      d_rsp_valid  <= grant_d;
      d_rsp_data   <= (grant_d && !sel_err && d_params.read_write) ? mem_data_out : '0;
      d_rsp_err    <= grant_d && sel_err;
    end
  end

endmodule
